// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: 50% duty clk_div = clk_i / N (N = 2..255), glitch-free switch/stop at period end.
// Latency: divided clock starts high 1 cycle after en; a new divisor takes effect the cycle after period_tick.
// Backpressure: one pending divisor slot; cfg_ready stays low until the pending value is applied at wrap.
module clk_div_ctrl (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       en,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_div,
    output logic       cfg_ready,
    output logic       err,
    output logic       clk_div,
    output logic       running,
    output logic       period_tick
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] div_reg, div_nxt;
    logic [7:0] pend_div, pend_div_nxt;
    logic       pend_vld, pend_vld_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       p, p_nxt;
    logic       q;
    logic       err_q, err_nxt;
    logic       wr_acc, wr_bad, wr_ok, wrap;

    assign cfg_ready   = !pend_vld;
    assign running     = (state == RUN);
    assign wrap        = (state == RUN) && (cnt == div_reg - 8'd1);
    assign period_tick = wrap;
    assign err         = err_q;
    // Odd N stretches the high phase by the half-cycle-late copy of p.
    assign clk_div     = div_reg[0] ? (p | q) : p;

    assign wr_acc = cfg_valid && cfg_ready;
    assign wr_bad = wr_acc && (cfg_div < 8'd2);
    assign wr_ok  = wr_acc && !wr_bad;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_reg  <= 8'd0;
            pend_div <= 8'd0;
            pend_vld <= 1'b0;
            cnt      <= 8'd0;
            p        <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_reg  <= div_nxt;
            pend_div <= pend_div_nxt;
            pend_vld <= pend_vld_nxt;
            cnt      <= cnt_nxt;
            p        <= p_nxt;
            err_q    <= err_nxt;
        end
    end

    always_ff @(negedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= p;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_nxt      = div_reg;
        pend_div_nxt = pend_div;
        pend_vld_nxt = pend_vld;
        cnt_nxt      = cnt;
        err_nxt      = wr_bad;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                if (wr_ok) begin
                    div_nxt = cfg_div;
                end
                if (en && (div_reg >= 8'd2)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (wrap) begin
                    cnt_nxt = 8'd0;
                    if (pend_vld) begin
                        div_nxt      = pend_div;
                        pend_vld_nxt = 1'b0;
                    end
                    if (!en) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
                // wr_ok implies pend_vld is clear, so this never collides with the wrap clear.
                if (wr_ok) begin
                    pend_div_nxt = cfg_div;
                    pend_vld_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        p_nxt = (state_nxt == RUN) && (cnt_nxt < {1'b0, div_nxt[7:1]});
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: divisor load, odd/even waveforms, pending switch, reject, stop, async reset.
module tb_clk_div_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       err;
    logic       clk_div;
    logic       running;
    logic       period_tick;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] cw;
    logic [31:0] tw;

    clk_div_ctrl dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .err         (err),
        .clk_div     (clk_div),
        .running     (running),
        .period_tick (period_tick)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cyc();
        cfg_valid = 1'b0;
    endtask

    // clk_div sampled twice per cycle (after posedge, after negedge), first sample in the MSB;
    // period_tick once per cycle after posedge.
    task automatic capture(input int n, output logic [63:0] c, output logic [31:0] t);
        c = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            c = {c[62:0], clk_div};
            t = {t[30:0], period_tick};
            #5;
            c = {c[62:0], clk_div};
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        #1 rst_n  = 1'b0;
        #11;
        chk("rst_clk_div", {63'd0, clk_div}, 64'd0);
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_running", {63'd0, running}, 64'd0);
        chk("rst_tick", {63'd0, period_tick}, 64'd0);
        #10 rst_n = 1'b1;
        cyc();

        // N=4: high 2 / low 2, tick every 4 cycles
        write(8'd4);
        chk("n4_idle_running", {63'd0, running}, 64'd0);
        en = 1'b1;
        cyc();
        chk("n4_running", {63'd0, running}, 64'd1);
        capture(8, cw, tw);
        chk("n4_wave", cw, 64'hF0F0);
        chk("n4_tick", {32'd0, tw}, 64'h11);

        // en dropped at period start: one full period then idle
        en = 1'b0;
        capture(5, cw, tw);
        chk("n4_stop_wave", cw, 64'h3C0);
        chk("n4_stop_tick", {32'd0, tw}, 64'h02);
        chk("n4_stop_running", {63'd0, running}, 64'd0);

        // N=3: high 1.5 / low 1.5
        write(8'd3);
        en = 1'b1;
        cyc();
        capture(6, cw, tw);
        chk("n3_wave", cw, 64'hE38);
        chk("n3_tick", {32'd0, tw}, 64'h09);
        chk("n3_running", {63'd0, running}, 64'd1);

        // pending switch 3 -> 5 at wrap
        write(8'd5);
        chk("p5_ready_low", {63'd0, cfg_ready}, 64'd0);
        capture(6, cw, tw);
        chk("p5_wave", cw, 64'h8F8);
        chk("p5_tick", {32'd0, tw}, 64'h10);
        chk("p5_ready_back", {63'd0, cfg_ready}, 64'd1);

        // N=5 running, write N=2 at cnt=2
        cyc();
        cyc();
        cyc();
        write(8'd2);
        chk("p2_ready_c3", {63'd0, cfg_ready}, 64'd0);
        chk("p2_tick_c3", {63'd0, period_tick}, 64'd0);
        cyc();
        chk("p2_ready_c4", {63'd0, cfg_ready}, 64'd0);
        chk("p2_tick_c4", {63'd0, period_tick}, 64'd1);
        cyc();
        chk("p2_ready_new", {63'd0, cfg_ready}, 64'd1);
        capture(4, cw, tw);
        chk("n2_wave", cw, 64'hCC);
        chk("n2_tick", {32'd0, tw}, 64'h5);

        // illegal divisors rejected
        write(8'd1);
        chk("bad1_err", {63'd0, err}, 64'd1);
        chk("bad1_ready", {63'd0, cfg_ready}, 64'd1);
        cyc();
        chk("bad1_err_clr", {63'd0, err}, 64'd0);
        write(8'd0);
        chk("bad0_err", {63'd0, err}, 64'd1);
        cyc();
        chk("bad0_err_clr", {63'd0, err}, 64'd0);
        capture(4, cw, tw);
        chk("bad_n2_wave", cw, 64'hCC);
        chk("bad_n2_tick", {32'd0, tw}, 64'h5);

        // N=7, en dropped at cnt=2
        write(8'd7);
        cyc();
        cyc();
        cyc();
        en = 1'b0;
        capture(6, cw, tw);
        chk("n7_stop_wave", cw, 64'hE00);
        chk("n7_stop_tick", {32'd0, tw}, 64'h02);
        chk("n7_stop_running", {63'd0, running}, 64'd0);
        chk("n7_stop_clk", {63'd0, clk_div}, 64'd0);

        // async reset while clk_div high
        en = 1'b1;
        cyc();
        chk("pre_rst_clk", {63'd0, clk_div}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clk", {63'd0, clk_div}, 64'd0);
        chk("async_rst_running", {63'd0, running}, 64'd0);
        chk("async_rst_ready", {63'd0, cfg_ready}, 64'd1);
        #2 rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_running", {63'd0, running}, 64'd0);
        chk("post_rst_clk", {63'd0, clk_div}, 64'd0);
        chk("post_rst_err", {63'd0, err}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, system clock; all state on posedge except one negedge flop (REQ-016).
REQ-002 SHALL have port rst_n, input, 1, reset; one clock, asynchronous, active-low.
REQ-003 SHALL have port en, input, 1, run request; 1 = generate divided clock, 0 = stop at period end.
REQ-004 SHALL have port cfg_valid, input, 1, divisor write request.
REQ-005 SHALL have port cfg_div, input, 8, requested divisor N; legal range 2..255.
REQ-006 SHALL have port cfg_ready, output, 1, write slot available.
REQ-007 SHALL have port err, output, 1, one-cycle pulse on rejected divisor.
REQ-008 SHALL have port clk_div, output, 1, divided clock, 50% duty for odd and even N.
REQ-009 SHALL have port running, output, 1, high in RUN state.
REQ-010 SHALL have port period_tick, output, 1, one-cycle pulse in last clk_i cycle of each divided period.

Function
REQ-011 SHALL hold registers div_reg[7:0] (active N), pend_div[7:0], pend_vld, cnt[7:0], and a 2-state FSM: IDLE, RUN.
REQ-012 SHALL accept a write when cfg_valid && cfg_ready; cfg_ready = !pend_vld.
REQ-013 SHALL, on accepted write with cfg_div < 2, leave all config unchanged and drive err = 1 in the next cycle only.
REQ-014 SHALL, on accepted legal write in IDLE, load div_reg directly; in RUN, load pend_div and set pend_vld.
REQ-015 SHALL, in RUN, increment cnt each cycle and wrap from div_reg-1 to 0; period_tick = RUN && cnt == div_reg-1.
REQ-016 SHALL form clk_div from posedge flag p (high while cnt in 0..floor(N/2)-1) and negedge flop q = p delayed half a clk_i cycle: even N -> clk_div = p; odd N -> clk_div = p | q (high N/2 clk_i periods).
REQ-017 SHALL transition IDLE -> RUN when en == 1 and div_reg >= 2; cnt = 0 in first RUN cycle.
REQ-018 SHALL, at a wrap cycle (period_tick), if pend_vld: copy pend_div to div_reg, clear pend_vld, restart cnt = 0 with new N; switch only at wrap, never mid-period.
REQ-019 SHALL, at a wrap cycle with en == 0, go to IDLE; en deassertion mid-period completes current period.
REQ-020 SHALL, when en == 0 and pend_vld coincide at wrap, go to IDLE and also load pend_div into div_reg.
REQ-021 SHALL, in IDLE, hold cnt = 0, p = q = 0, clk_div = 0, running = 0, period_tick = 0.
REQ-022 SHALL ignore en while in IDLE if div_reg < 2 (stay IDLE, no err).
REQ-023 SHALL produce no clk_div pulse shorter than floor(N/2) clk_i cycles at any switch or stop.

Reset
REQ-024 SHALL, while rst_n == 0, force asynchronously: FSM = IDLE, div_reg = 0, pend_div = 0, pend_vld = 0, cnt = 0, p = 0, q = 0.
REQ-025 SHALL hold outputs during reset: clk_div = 0, cfg_ready = 1, err = 0, running = 0, period_tick = 0.
REQ-026 SHALL, on reset assertion mid-RUN, drop clk_div to 0 without waiting for any clock edge.

Verification
REQ-027 SHALL cover: write N=4 in IDLE, en=1 -> clk_div high 2 / low 2 clk_i cycles, period_tick every 4 cycles.
REQ-028 SHALL cover: N=3, en=1 -> clk_div high 1.5 / low 1.5 clk_i cycles, 50% duty, running=1.
REQ-029 SHALL cover: in RUN N=5, write N=2 mid-period -> cfg_ready=0 until wrap; first N=2 period starts cycle after period_tick.
REQ-030 SHALL cover: write cfg_div=1 and cfg_div=0 -> err pulses one cycle each, div_reg unchanged, output unaffected.
REQ-031 SHALL cover: N=7 running, en=0 at cnt=2 -> period completes, IDLE after wrap, clk_div=0, running=0.
REQ-032 SHALL cover: rst_n=0 while clk_div high -> clk_div=0 immediately; after release, en=1 without new write stays IDLE (div_reg=0).
